// File: rtl/rob_param_if.sv
// rtl/rob_param_if.sv - issue, writeback, query and retire signal bundle for rob_param
interface rob_param_if #(
  parameter int ID_W   = 4,
  parameter int NUM_WB = 2
);
  logic                   iss_valid;
  logic                   iss_ready;
  logic [ID_W-1:0]        iss_id;
  logic [31:0]            iss_pc;
  logic [31:0]            iss_pred;
  logic [1:0]             iss_type;
  logic [4:0]             iss_rd;
  logic [NUM_WB-1:0]      wb_valid;
  logic [NUM_WB*ID_W-1:0] wb_id;
  logic [NUM_WB*32-1:0]   wb_val;
  logic [ID_W-1:0]        qry_id_1;
  logic [ID_W-1:0]        qry_id_2;
  logic                   qry_ready_1;
  logic                   qry_ready_2;
  logic [31:0]            qry_val_1;
  logic [31:0]            qry_val_2;
  logic                   cmt_valid;
  logic [ID_W-1:0]        cmt_id;
  logic [4:0]             cmt_rd;
  logic [31:0]            cmt_val;
  logic                   st_commit;
  logic [ID_W-1:0]        st_id;
  logic                   flush;
  logic [31:0]            flush_pc;
  logic [ID_W:0]          count;

  modport master (
    output iss_valid, iss_pc, iss_pred, iss_type, iss_rd,
    output wb_valid, wb_id, wb_val, qry_id_1, qry_id_2,
    input  iss_ready, iss_id, qry_ready_1, qry_ready_2, qry_val_1, qry_val_2,
    input  cmt_valid, cmt_id, cmt_rd, cmt_val, st_commit, st_id, flush, flush_pc, count
  );

  modport slave (
    input  iss_valid, iss_pc, iss_pred, iss_type, iss_rd,
    input  wb_valid, wb_id, wb_val, qry_id_1, qry_id_2,
    output iss_ready, iss_id, qry_ready_1, qry_ready_2, qry_val_1, qry_val_2,
    output cmt_valid, cmt_id, cmt_rd, cmt_val, st_commit, st_id, flush, flush_pc, count
  );
endinterface

// File: rtl/rob_param.sv
// rtl/rob_param.sv - parametrised reorder buffer; ROB_BYPASS_EN adds writeback-to-query bypass
module rob_param #(
  parameter int DEPTH  = 16,
  parameter int ID_W   = 4,
  parameter int NUM_WB = 2
) (
  input logic        clk_in,
  input logic        rst_in,
  input logic        rdy_in,
  rob_param_if.slave bus
);
  localparam logic [1:0]    T_REG    = 2'd0;
  localparam logic [1:0]    T_BR     = 2'd1;
  localparam logic [1:0]    T_ST     = 2'd2;
  localparam logic [1:0]    T_LD     = 2'd3;
  localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(DEPTH);

  logic [DEPTH-1:0] busy_q, done_q;
  logic [1:0]       type_q [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      pred_q [DEPTH];
  logic [31:0]      val_q  [DEPTH];

  logic [ID_W-1:0]  head_q, tail_q;
  logic [ID_W:0]    count_q;
  logic             cmt_valid_q, st_commit_q, flush_q;
  logic [ID_W-1:0]  cmt_id_q, st_id_q;
  logic [4:0]       cmt_rd_q;
  logic [31:0]      cmt_val_q, flush_pc_q;

  logic             iss_we, do_cmt;
  logic [NUM_WB-1:0] wb_we;
  logic [ID_W-1:0]  wb_tag  [NUM_WB];
  logic [31:0]      wb_data [NUM_WB];
  logic             q1_rdy, q2_rdy;
  logic [31:0]      q1_val, q2_val;

  assign bus.iss_ready = (count_q != FULL_CNT);
  assign bus.iss_id    = tail_q;
  assign bus.count     = count_q;
  assign bus.cmt_valid = cmt_valid_q;
  assign bus.cmt_id    = cmt_id_q;
  assign bus.cmt_rd    = cmt_rd_q;
  assign bus.cmt_val   = cmt_val_q;
  assign bus.st_commit = st_commit_q;
  assign bus.st_id     = st_id_q;
  assign bus.flush     = flush_q;
  assign bus.flush_pc  = flush_pc_q;

  // The flush cycle swallows issue, writeback and retirement alike.
  assign iss_we = rdy_in & bus.iss_valid & bus.iss_ready & ~flush_q;
  assign do_cmt = rdy_in & busy_q[head_q] & done_q[head_q] & ~flush_q;

  // Unpack writeback channels; results aimed at idle slots are dropped.
  always_comb begin
    for (int k = 0; k < NUM_WB; k++) begin
      wb_tag[k]  = bus.wb_id[k*ID_W +: ID_W];
      wb_data[k] = bus.wb_val[k*32 +: 32];
      wb_we[k]   = rdy_in & ~flush_q & bus.wb_valid[k] & busy_q[wb_tag[k]];
    end
  end

  // Operand lookup from entry state, optionally overridden by live writebacks.
  always_comb begin
    q1_rdy = busy_q[bus.qry_id_1] & done_q[bus.qry_id_1];
    q1_val = val_q[bus.qry_id_1];
    q2_rdy = busy_q[bus.qry_id_2] & done_q[bus.qry_id_2];
    q2_val = val_q[bus.qry_id_2];
`ifdef ROB_BYPASS_EN
    for (int k = 0; k < NUM_WB; k++) begin
      if (bus.wb_valid[k] && wb_tag[k] == bus.qry_id_1) begin
        q1_rdy = 1'b1;
        q1_val = wb_data[k];
      end
      if (bus.wb_valid[k] && wb_tag[k] == bus.qry_id_2) begin
        q2_rdy = 1'b1;
        q2_val = wb_data[k];
      end
    end
`endif
  end

  assign bus.qry_ready_1 = q1_rdy;
  assign bus.qry_val_1   = q1_val;
  assign bus.qry_ready_2 = q2_rdy;
  assign bus.qry_val_2   = q2_val;

  // Entry payload; validity lives in busy/done so no reset is needed here.
  always_ff @(posedge clk_in) begin
    if (iss_we) begin
      type_q[tail_q] <= bus.iss_type;
      rd_q[tail_q]   <= bus.iss_rd;
      pred_q[tail_q] <= bus.iss_pred;
    end
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_we[k]) val_q[wb_tag[k]] <= wb_data[k];
    end
  end

  // Pointers, entry status and registered retire pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q      <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cmt_valid_q <= 1'b0;
      st_commit_q <= 1'b0;
      flush_q     <= 1'b0;
      cmt_id_q    <= '0;
      cmt_rd_q    <= '0;
      cmt_val_q   <= '0;
      st_id_q     <= '0;
      flush_pc_q  <= '0;
    end else if (rdy_in) begin
      if (flush_q) begin
        busy_q      <= '0;
        done_q      <= '0;
        head_q      <= '0;
        tail_q      <= '0;
        count_q     <= '0;
        cmt_valid_q <= 1'b0;
        st_commit_q <= 1'b0;
        flush_q     <= 1'b0;
      end else begin
        cmt_valid_q <= 1'b0;
        st_commit_q <= 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
          if (wb_we[k]) done_q[wb_tag[k]] <= 1'b1;
        end
        if (do_cmt) begin
          busy_q[head_q] <= 1'b0;
          done_q[head_q] <= 1'b0;
          head_q         <= head_q + ID_W'(1);
          case (type_q[head_q])
            T_REG, T_LD: begin
              cmt_valid_q <= 1'b1;
              cmt_id_q    <= head_q;
              cmt_rd_q    <= rd_q[head_q];
              cmt_val_q   <= val_q[head_q];
            end
            T_ST: begin
              st_commit_q <= 1'b1;
              st_id_q     <= head_q;
            end
            T_BR: begin
              if (val_q[head_q] != pred_q[head_q]) begin
                flush_q    <= 1'b1;
                flush_pc_q <= val_q[head_q];
              end
            end
          endcase
        end
        if (iss_we) begin
          busy_q[tail_q] <= 1'b1;
          done_q[tail_q] <= 1'b0;
          tail_q         <= tail_q + ID_W'(1);
        end
        count_q <= count_q + (ID_W+1)'(iss_we) - (ID_W+1)'(do_cmt);
      end
    end
  end
endmodule

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer: the successor of the fixed-size ROB. Instructions are allocated in program order from the decoder. Results arrive out of order on `NUM_WB` writeback channels. Entries retire strictly in order at one per cycle. On retirement the block drives the register-file commit, the store release to the LSB, and branch-mispredict flush with a redirect PC. Occupancy is tracked with a counter, so every one of `DEPTH` slots is usable.

## Interface
- `DEPTH`, 16: entry count; power of two, at least 4.
- `ID_W`, 4: tag width; must equal log2(`DEPTH`).
- `NUM_WB`, 2: writeback channels, 1..4.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global enable; low freezes all state and outputs.
- `iss_valid` in 1: decoder presents an instruction.
- `iss_ready` out 1: equals (count != `DEPTH`).
- `iss_id` out ID_W: tag the next issue receives (tail).
- `iss_pc` in 32: instruction address.
- `iss_pred` in 32: predicted next PC.
- `iss_type` in 2: 0 reg-writing, 1 branch, 2 store, 3 load.
- `iss_rd` in 5: destination register.
- `wb_valid` in NUM_WB: per-channel writeback strobe.
- `wb_id` in NUM_WB*ID_W: channel k occupies bits [k*ID_W +: ID_W].
- `wb_val` in NUM_WB*32: result. For a branch this is the actual next PC.
- `qry_id_1`/`qry_id_2` in ID_W: operand lookup tags.
- `qry_ready_1`/`qry_ready_2` out 1: the tagged entry is busy and done.
- `qry_val_1`/`qry_val_2` out 32: the tagged entry's value.
- `cmt_valid` out 1: one-cycle retire pulse for types 0 and 3.
- `cmt_id` out ID_W, `cmt_rd` out 5, `cmt_val` out 32: the retired entry's tag, destination and value.
- `st_commit` out 1, `st_id` out ID_W: one-cycle store release pulse and the store's tag.
- `flush` out 1, `flush_pc` out 32: mispredict pulse and the redirect target.
- `count` out ID_W+1: current occupancy.

## Operation
- Each entry holds: busy, done, type, rd, pc, pred, val. Pointers are `head`, `tail` and `count`.
- **Issue.** On the rising edge, when `rdy_in & iss_valid & iss_ready & !flush`:
  - write the entry at `tail`, setting busy=1 and done=0;
  - `tail` increments modulo `DEPTH`.
  - When `iss_ready`=0 the issue is dropped and nothing changes.
- **Writeback.** For each channel k with `wb_valid[k]` and `!flush`: set done=1 and val=`wb_val[k]`.
  - A writeback to a non-busy entry is ignored.
  - If two channels target the same tag, the higher k wins.
- **Commit.** When the `head` entry is busy and done (registered state), retire it: busy=0 and `head` increments modulo `DEPTH`.
  - Type 0/3: pulse `cmt_valid` with `cmt_id`/`cmt_rd`/`cmt_val`. This happens even when rd=0, so the regfile can clear its tag.
  - Type 2: pulse `st_commit` with `st_id`=head. `cmt_valid` stays 0.
  - Type 1: if val != pred, set `flush`=1 and `flush_pc`=val. Otherwise no output pulse.
- **Count.** `count` changes by +issue−commit. A simultaneous issue and commit leaves it unchanged.
- **Flush cycle.** While `flush`=1 and `rdy_in`=1, the next edge does the following:
  - clears all busy/done bits and sets head=tail=count=0;
  - drops that cycle's issue and writeback;
  - commits nothing;
  - deasserts `flush`.
- **Reset** (rst_in low, immediate):
  - head=tail=count=0 and every busy/done bit is 0;
  - `cmt_valid`, `st_commit` and `flush` are 0;
  - `cmt_id`, `cmt_rd`, `cmt_val`, `st_id` and `flush_pc` are 0.
  - A reset mid-flush or mid-commit discards everything.
- Query outputs are combinational from entry state. A query of a non-busy tag gives ready=0 and val=stored value (don't-care).

## Timing
- Issue at edge N: the entry is visible to commit and query after edge N.
- Writeback at edge N: the earliest commit is at edge N+1. `cmt_valid` is high during the cycle after N+1.
- `cmt_valid`, `st_commit` and `flush` are registered, 1-cycle pulses. When another retire follows, they stay high for consecutive cycles.
- Mispredicted branch retired at edge N: `flush` is high during cycle N→N+1, and the ROB is empty after N+1.
- `iss_ready` comes from registered `count` only. A full ROB that commits at edge N accepts an issue at edge N+1, not at N.
- `rdy_in` low: no state changes, and the pulse outputs hold their current values.

## Configuration
- `ROB_BYPASS_EN` defined: a query also hits same-cycle writebacks.
  - If a `wb_valid[k]` channel has `wb_id[k]`==qry id, return ready=1 and val=`wb_val[k]`, with the highest k taking priority.
  - Otherwise fall back to entry state.
- Undefined: queries reflect registered entry state only, so a writeback becomes visible one cycle later.

## Test plan
- Reset:
  - Stimulus: assert `rst_in` low mid-run (with outstanding entries), then release.
  - Required: `count`=0, `iss_ready`=1, `iss_id`=0, and all pulses 0; no commits until new issues.
- Full:
  - Stimulus: 16 issues with no writeback, then a 17th issue, then writeback of tag 0 with 0x55.
  - Required: `iss_ready`=0 at count 16, and the 17th issue is ignored.
  - Required after the writeback: `cmt_valid`=1, `cmt_id`=0, `cmt_val`=0x55; `iss_ready`=1 one cycle later.
- Out-of-order writeback:
  - Stimulus: issue three type-0 entries with rd 1/2/3; write back tags 2, 1, 0 in three successive cycles with values 0xA/0xB/0xC.
  - Required: three back-to-back `cmt_valid` pulses for rd 1, 2, 3 with values 0xC, 0xB, 0xA, in order.
- Mispredict:
  - Stimulus: issue a branch (pred 0x1004) and two type-0 entries; write back all three; the branch value is 0x2000.
  - Required: `flush`=1 for one cycle with `flush_pc`=0x2000, then `count`=0 and `iss_id`=0; the younger entries never produce `cmt_valid`.
- Store:
  - Stimulus: issue a store as tag 0, then write back tag 0.
  - Required: `st_commit`=1 with `st_id`=0; `cmt_valid` stays 0.
- Wrap and bypass:
  - Stimulus: cycle 20 instructions through the buffer. Then query tag 3 in the same cycle as `wb_id[1]`=3 with value 0x77.
  - Required after wrap: tags issue 0..15 then 0..3, and all commits are in order.
  - Required on the query: with `ROB_BYPASS_EN`, `qry_ready_1`=1 and `qry_val_1`=0x77 in that cycle; without it, these appear one cycle later.
